// File: rtl/uart_pkg.sv
// Shared UART constants: default word width, FIFO address width and
// almost-full threshold used by the receiver, the RX FIFO and the transmitter.
package uart_pkg;

    localparam int DEF_D_BIT    = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AF_LEVEL = 12;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: 2**ADDR_W x D_BIT register file with one synchronous write
// port and one combinational read port. Storage is deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int D_BIT  = DEF_D_BIT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [D_BIT-1:0]  w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [D_BIT-1:0]  r_data
);

    logic [D_BIT-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[w_addr] <= w_data;
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through, with sticky overflow flag.
// Define UART_RX_FIFO_AF_EN to add the almost_full output (count >= AF_LEVEL).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int D_BIT    = DEF_D_BIT,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [D_BIT-1:0]  w_data,
    input  logic              rd,
    output logic [D_BIT-1:0]  r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef UART_RX_FIFO_AF_EN
    output logic              almost_full,
`endif
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH);
    assign count    = count_q;
    assign overflow = overflow_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign push_ok = wr && (!full || rd);
    assign pop_ok  = rd && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) w_ptr <= w_ptr + 1'b1;
            if (pop_ok)  r_ptr <= r_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Set has priority over clear so a coincident drop is never lost.
            if (wr && full && !rd) overflow_q <= 1'b1;
            else if (clr_ovf)      overflow_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W+1)'(AF_LEVEL);
    assign almost_full = (count_q >= AF_CNT);
`endif

    uart_fifo_mem #(
        .D_BIT  (D_BIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (push_ok),
        .w_addr (w_ptr),
        .w_data (w_data),
        .r_addr (r_ptr),
        .r_data (r_data)
    );

endmodule
